// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting datapath and serial_add_ctrl.
// Optional macro SERIAL_ADD_SUB_EN adds the 'sub' request bit.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller time-sharing one external full-adder cell, LSB first.
// Optional macro SERIAL_ADD_SUB_EN enables subtraction via bus.sub (a - b).
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  serial_add_ctrl_if.slave  bus,
  output logic              fa_op1,
  output logic              fa_op2,
  output logic              fa_op3,
  input  logic              fa_sum,
  input  logic              fa_carry
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_b_in;
  logic             w_carry_in;

  // Subtraction is a + ~b + 1; cout=1 then means no borrow.
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_in     = bus.sub ? ~bus.b : bus.b;
  assign w_carry_in = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_b_in     = bus.b;
  assign w_carry_in = bus.cin;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= w_b_in;
            r_carry <= w_carry_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[r_cnt] <= fa_sum;
          r_carry      <= fa_carry;
          r_cnt        <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_cout  <= fa_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The shared adder only sees live operands while RUN; otherwise it idles at zero.
  always_comb begin
    fa_op1 = 1'b0;
    fa_op2 = 1'b0;
    fa_op3 = 1'b0;
    if (r_state == RUN) begin
      fa_op1 = r_a[r_cnt];
      fa_op2 = r_b[r_cnt];
      fa_op3 = r_carry;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule
